// File: rtl/cache_mem_arbiter.sv
// Memory-side responder for the caches: arbitrates icache reads and dcache reads/writes
// onto one RAM port, dcache first, with a starvation guard that forces the icache ahead.
module cache_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [DATA_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dwait,
   output logic [DATA_W-1:0] dload,
   output logic              ram_ren,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_store,
   input  logic [DATA_W-1:0] ram_load,
   input  logic              ram_ready
);

   localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

   state_t            state, state_nxt;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              wr_q;
   logic [DATA_W-1:0] iload_q, dload_q;
   logic              dpend, dgrant, igrant, idone, ddone;

   assign dpend  = dREN | dWEN;
   assign dgrant = (state == IDLE) && dpend && !(iREN && (cnt == CNT_MAX));
   assign igrant = (state == IDLE) && !dgrant && iREN;
   // A request dropped while busy is an abort and beats a simultaneous ram_ready.
   assign idone  = (state == IBUSY) && iREN && ram_ready && !RST;
   assign ddone  = (state == DBUSY) && dpend && ram_ready && !RST;

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (dgrant)      state_nxt = DBUSY;
            else if (igrant) state_nxt = IBUSY;
         end
         IBUSY:   if (!iREN || ram_ready)  state_nxt = IDLE;
         DBUSY:   if (!dpend || ram_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ram_ren   = 1'b0;
      ram_wen   = 1'b0;
      ram_addr  = '0;
      ram_store = '0;
      case (state)
         IBUSY: begin
            ram_ren  = 1'b1;
            ram_addr = addr_q;
         end
         DBUSY: begin
            ram_ren   = !wr_q;
            ram_wen   = wr_q;
            ram_addr  = addr_q;
            ram_store = data_q;
         end
         default: ;
      endcase
      iwait = !idone;
      dwait = !ddone;
      iload = idone ? ram_load : iload_q;
      dload = (ddone && !wr_q) ? ram_load : dload_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt     <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         iload_q <= '0;
         dload_q <= '0;
      end else begin
         if (dgrant) begin
            addr_q <= daddr;
            data_q <= dstore;
            wr_q   <= dWEN;
            if (!iREN)                cnt <= '0;
            else if (cnt != CNT_MAX)  cnt <= cnt + 4'd1;
         end else if (igrant) begin
            addr_q <= iaddr;
            wr_q   <= 1'b0;
            cnt    <= '0;
         end
         if (idone)           iload_q <= ram_load;
         if (ddone && !wr_q)  dload_q <= ram_load;
      end
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized and directed bench for cache_mem_arbiter, checked every cycle against a
// transaction-level model of the arbiter plus literal expectations for the main scenarios.
module tb_cache_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SM = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          iREN, dREN, dWEN, ram_ready;
   logic [AW-1:0] iaddr, daddr;
   logic [DW-1:0] dstore, ram_load;
   logic          iwait, dwait, ram_ren, ram_wen;
   logic [DW-1:0] iload, dload, ram_store;
   logic [AW-1:0] ram_addr;

   cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
      .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: the transaction currently owning the RAM (0 none, 1 icache, 2 dcache).
   int          m_who = 0;
   bit          m_wr = 1'b0;
   logic [31:0] m_addr = '0, m_data = '0, m_il = '0, m_dl = '0;
   int          m_cnt = 0;
   logic [63:0] m_glog = '0;
   int          m_ngrant = 0;

   always @(posedge CLK) begin
      if (RST) begin
         m_who <= 0; m_wr <= 1'b0; m_addr <= '0; m_data <= '0;
         m_cnt <= 0; m_il <= '0; m_dl <= '0;
      end else if (m_who == 0) begin
         if ((dREN || dWEN) && !(iREN && m_cnt == SM)) begin
            m_who <= 2; m_wr <= dWEN; m_addr <= daddr; m_data <= dstore;
            m_cnt <= iREN ? ((m_cnt + 1 > SM) ? SM : m_cnt + 1) : 0;
            m_glog <= {m_glog[62:0], 1'b0}; m_ngrant <= m_ngrant + 1;
         end else if (iREN) begin
            m_who <= 1; m_addr <= iaddr; m_cnt <= 0;
            m_glog <= {m_glog[62:0], 1'b1}; m_ngrant <= m_ngrant + 1;
         end
      end else if (m_who == 1) begin
         if (!iREN) m_who <= 0;
         else if (ram_ready) begin m_il <= ram_load; m_who <= 0; end
      end else begin
         if (!(dREN || dWEN)) m_who <= 0;
         else if (ram_ready) begin
            if (!m_wr) m_dl <= ram_load;
            m_who <= 0;
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         logic e_iw, e_dw;
         e_iw = !(m_who == 1 && iREN && ram_ready && !RST);
         e_dw = !(m_who == 2 && (dREN || dWEN) && ram_ready && !RST);
         chk("ram_ren", ram_ren, m_who == 1 || (m_who == 2 && !m_wr));
         chk("ram_wen", ram_wen, m_who == 2 && m_wr);
         chk("ram_addr", ram_addr, (m_who != 0) ? m_addr : 32'h0);
         chk("ram_store", ram_store, (m_who == 2) ? m_data : 32'h0);
         chk("iwait", iwait, e_iw);
         chk("dwait", dwait, e_dw);
         chk("iload", iload, !e_iw ? ram_load : m_il);
         chk("dload", dload, (!e_dw && !m_wr) ? ram_load : m_dl);
      end
   end

   task automatic nxt();
      @(posedge CLK); #1;
   endtask

   task automatic smp();
      @(negedge CLK);
   endtask

   initial begin
      logic [6:0] order;
      int dleft, ncomp, g0;
      bit idone;

      RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
      iaddr = '0; daddr = '0; dstore = '0; ram_load = '0;
      nxt(); chk_en = 1'b1; nxt();
      RST = 1'b0;

      // Isolated icache read, RAM ready two cycles after the strobe appears.
      iREN = 1; iaddr = 32'h40;
      smp();
      chk("rst_iwait", iwait, 1); chk("rst_dwait", dwait, 1);
      chk("rst_ren", ram_ren, 0); chk("rst_wen", ram_wen, 0);
      chk("rst_addr", ram_addr, 0); chk("rst_store", ram_store, 0);
      chk("rst_iload", iload, 0); chk("rst_dload", dload, 0);
      nxt(); smp();
      chk("i_ren_c1", ram_ren, 1); chk("i_addr_c1", ram_addr, 32'h40); chk("i_wait_c1", iwait, 1);
      nxt(); smp();
      chk("i_wait_c2", iwait, 1);
      nxt(); ram_ready = 1; ram_load = 32'hDEADBEEF; smp();
      chk("i_wait_c3", iwait, 0); chk("i_load_c3", iload, 32'hDEADBEEF); chk("i_dwait_c3", dwait, 1);
      nxt(); iREN = 0; ram_ready = 0; ram_load = '0; smp();
      chk("i_wait_c4", iwait, 1); chk("i_load_hold", iload, 32'hDEADBEEF); chk("i_ren_c4", ram_ren, 0);

      // Simultaneous requests: dcache first, one idle cycle, then icache.
      nxt(); iREN = 1; iaddr = 32'h100; dREN = 1; daddr = 32'h200;
      ram_ready = 1; ram_load = 32'hA5A50001; smp();
      nxt(); smp();
      chk("sim_d_addr", ram_addr, 32'h200); chk("sim_d_wait", dwait, 0);
      chk("sim_d_load", dload, 32'hA5A50001); chk("sim_d_iwait", iwait, 1);
      nxt(); dREN = 0; ram_load = 32'hA5A50002; smp();
      chk("sim_gap_ren", ram_ren, 0);
      nxt(); smp();
      chk("sim_i_addr", ram_addr, 32'h100); chk("sim_i_wait", iwait, 0);
      chk("sim_i_load", iload, 32'hA5A50002);
      nxt(); iREN = 0;

      // Starvation guard: icache waits behind four dcache grants, then goes ahead.
      g0 = m_ngrant; dleft = 6; ncomp = 0; idone = 0; order = '0; iaddr = 32'h700;
      for (int c = 0; c < 40 && ncomp < 7; c++) begin
         dREN = (dleft > 0); daddr = 32'h1000 + 32'(dleft * 4);
         iREN = !idone; ram_load = $urandom;
         smp();
         if (!dwait) begin order = {order[5:0], 1'b0}; ncomp++; dleft--; end
         if (!iwait) begin order = {order[5:0], 1'b1}; ncomp++; idone = 1; end
         nxt();
      end
      dREN = 0; iREN = 0;
      chk("starve_ncomp", ncomp, 7);
      chk("starve_order", order, 7'b0000100);
      chk("model_ngrant", m_ngrant - g0, 7);
      chk("model_order", m_glog[6:0], 7'b0000100);

      // Write, then dREN+dWEN together behaves as a write.
      ram_ready = 0; dWEN = 1; daddr = 32'h80; dstore = 32'h12345678; smp();
      nxt(); dstore = 32'hFFFF0000; smp();
      chk("w_wen", ram_wen, 1); chk("w_ren", ram_ren, 0); chk("w_addr", ram_addr, 32'h80);
      chk("w_store", ram_store, 32'h12345678); chk("w_dwait_c1", dwait, 1);
      nxt(); smp();
      nxt(); ram_ready = 1; smp();
      chk("w_dwait_c3", dwait, 0); chk("w_store_c3", ram_store, 32'h12345678);
      nxt(); dWEN = 0; ram_ready = 0; smp();
      chk("w_dwait_c4", dwait, 1); chk("w_wen_c4", ram_wen, 0);
      nxt(); dREN = 1; dWEN = 1; daddr = 32'h84; dstore = 32'hCAFEF00D; ram_ready = 1; smp();
      nxt(); smp();
      chk("rw_wen", ram_wen, 1); chk("rw_ren", ram_ren, 0);
      chk("rw_store", ram_store, 32'hCAFEF00D); chk("rw_dwait", dwait, 0);
      nxt(); dREN = 0; dWEN = 0; ram_ready = 0;

      // Abort: icache drops iREN while busy, same cycle as ram_ready.
      iREN = 1; iaddr = 32'h300; smp();
      nxt(); smp();
      chk("ab_ren_c1", ram_ren, 1);
      nxt(); iREN = 0; ram_ready = 1; ram_load = 32'h55; smp();
      chk("ab_iwait_c2", iwait, 1);
      nxt(); smp();
      chk("ab_ren_c3", ram_ren, 0); chk("ab_iwait_c3", iwait, 1);
      nxt(); smp();
      chk("ab_iwait_c4", iwait, 1);
      nxt(); ram_ready = 0;

      // Reset in the middle of a write, then a normal request.
      dWEN = 1; daddr = 32'h500; dstore = 32'h0BADF00D; smp();
      nxt(); smp();
      chk("rw_mid_wen", ram_wen, 1);
      nxt(); RST = 1; smp();
      nxt(); RST = 0; dWEN = 0; smp();
      chk("rr_wen", ram_wen, 0); chk("rr_ren", ram_ren, 0); chk("rr_dwait", dwait, 1);
      chk("rr_iwait", iwait, 1); chk("rr_addr", ram_addr, 0); chk("rr_dload", dload, 0);
      nxt(); dREN = 1; daddr = 32'h600; iREN = 1; iaddr = 32'h604; ram_ready = 1; smp();
      nxt(); smp();
      chk("rr_d_addr", ram_addr, 32'h600); chk("rr_d_dwait", dwait, 0); chk("rr_d_ren", ram_ren, 1);
      nxt(); dREN = 0; smp();
      nxt(); smp();
      chk("rr_i_addr", ram_addr, 32'h604); chk("rr_i_iwait", iwait, 0);
      nxt(); iREN = 0; ram_ready = 0;

      // Random traffic with aborts, changing inputs while busy and occasional resets.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) iREN = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 3) == 0) dREN = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 5) == 0) dWEN = $urandom_range(0, 2) == 0;
         iaddr = $urandom; daddr = $urandom; dstore = $urandom; ram_load = $urandom;
         ram_ready = $urandom_range(0, 2) == 0;
         RST = $urandom_range(0, 199) == 0;
         nxt();
      end
      RST = 0; iREN = 0; dREN = 0; dWEN = 0;
      nxt(); nxt();
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
